// File: rtl/sub32_iter.sv
// sub32_iter: multi-cycle unsigned subtractor with borrow.
// Computes {bout_r, diff_r} = a - b - bin one CHUNK-bit slice per enabled cycle,
// LSB slice first, rippling the borrow between slices.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   enable  in   global advance; low holds all state
//   start   in   request a new operation (sampled in IDLE only)
//   a, b    in   minuend / subtrahend (sampled on the accepting edge)
//   bin     in   borrow in (sampled on the accepting edge)
//   busy    out  high in RUN and DONE
//   done    out  high for one enabled cycle when the result is valid
//   diff_r  out  registered difference
//   bout_r  out  registered borrow out (1 iff a < b + bin)
module sub32_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_r,
    output logic             bout_r
);

    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [31:0]      w_lsb;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK:0]   w_sub;
    logic             w_last;

    // Current slice: CHUNK+1-bit subtraction, MSB of the result is the slice borrow.
    assign w_lsb     = 32'(r_cnt) * CHUNK;
    assign w_a_slice = r_a[w_lsb +: CHUNK];
    assign w_b_slice = r_b[w_lsb +: CHUNK];
    assign w_sub     = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{CHUNK{1'b0}}, r_borrow};
    assign w_last    = (r_cnt == CW'(NSLICE - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (enable) begin
            case (r_state)
                StIdle:  if (start) w_state_next = StRun;
                StRun:   if (w_last) w_state_next = StDone;
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (enable) begin
            case (r_state)
                StIdle: begin
                    // Previous result stays visible until the first slice overwrites it.
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                StRun: begin
                    r_diff[w_lsb +: CHUNK] <= w_sub[CHUNK-1:0];
                    r_borrow               <= w_sub[CHUNK];
                    r_cnt                  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bout <= w_sub[CHUNK];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state != StIdle);
    assign done   = (r_state == StDone);
    assign diff_r = r_diff;
    assign bout_r = r_bout;

endmodule

// File: tb/tb_sub32_iter.sv
module tb_sub32_iter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff_r;
    logic        bout_r;

    int n_checks;
    int n_pass;

    sub32_iter #(
        .WIDTH(32),
        .CHUNK(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff_r (diff_r),
        .bout_r (bout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide unsigned arithmetic.
    function automatic logic [31:0] ref_diff(input logic [31:0] x, input logic [31:0] y,
                                             input logic c);
        logic [63:0] full;
        full = {32'b0, x} - {32'b0, y} - {63'b0, c};
        return full[31:0];
    endfunction

    function automatic logic ref_bout(input logic [31:0] x, input logic [31:0] y,
                                      input logic c);
        return (64'(x) < (64'(y) + 64'(c)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation, checking handshake timing and result; operands are
    // scrambled right after acceptance to prove internal copies are used.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                          input string tag);
        a      = x;
        b      = y;
        bin    = c;
        start  = 1'b1;
        enable = 1'b1;
        tick();  // E0
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        bin   = 1'($urandom);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check({tag, "_busy_run"}, 64'(busy), 64'd1);
            check({tag, "_done_early"}, 64'(done), 64'd0);
        end
        tick();  // E4
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check({tag, "_diff"}, 64'(diff_r), 64'(ref_diff(x, y, c)));
        check({tag, "_bout"}, 64'(bout_r), 64'(ref_bout(x, y, c)));
        tick();  // E5
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        check({tag, "_busy_clr"}, 64'(busy), 64'd0);
        check({tag, "_diff_hold"}, 64'(diff_r), 64'(ref_diff(x, y, c)));
    endtask

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        qc[$];

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ec;
        int          p;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", 64'(diff_r), 64'd0);
        check("rst_bout", 64'(bout_r), 64'd0);
        tick();
        rst    = 1'b1;
        enable = 1'b1;
        tick();

        // Directed cases
        run_op(32'd5, 32'd3, 1'b0, "basic");
        run_op(32'd0, 32'd1, 1'b0, "underflow");
        run_op(32'h0100_0000, 32'h0000_0001, 1'b0, "ripple");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "allones_bin");

        // Random operations
        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom, 1'($urandom), "rand");
        end

        // Stall plus ignored start while busy
        a     = 32'h1234_5678;
        b     = 32'h0102_0304;
        bin   = 1'b0;
        start = 1'b1;
        tick();  // accept
        tick();  // slice 0, start still high while busy
        start = 1'b0;
        tick();  // slice 1
        enable = 1'b0;
        start  = 1'b1;
        tick();
        tick();
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_done", 64'(done), 64'd0);
        enable = 1'b1;
        start  = 1'b0;
        tick();  // slice 2
        check("stall_done_early", 64'(done), 64'd0);
        tick();  // slice 3
        check("stall_done", 64'(done), 64'd1);
        check("stall_diff", 64'(diff_r), 64'h1132_5374);
        check("stall_bout", 64'(bout_r), 64'd0);
        enable = 1'b0;
        tick();
        check("done_held", 64'(done), 64'd1);
        enable = 1'b1;
        tick();
        check("stall_done_clr", 64'(done), 64'd0);
        tick();
        check("no_queued_op", 64'(busy), 64'd0);

        // Asynchronous reset mid-run
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_1111;
        bin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_diff", 64'(diff_r), 64'd0);
        check("midrst_bout", 64'(bout_r), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        run_op(32'd10, 32'd20, 1'b0, "after_rst");

        // Back-to-back with start held high: one accept every 6 cycles
        p     = 0;
        start = 1'b1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            a   = $urandom;
            b   = $urandom;
            bin = 1'($urandom);
            if (p == 0) begin
                qa.push_back(a);
                qb.push_back(b);
                qc.push_back(bin);
            end
            tick();
            p = (p + 1) % 6;
            if (p == 5) begin
                check("b2b_done", 64'(done), 64'd1);
                ea = qa.pop_front();
                eb = qb.pop_front();
                ec = qc.pop_front();
                check("b2b_diff", 64'(diff_r), 64'(ref_diff(ea, eb, ec)));
                check("b2b_bout", 64'(bout_r), 64'(ref_bout(ea, eb, ec)));
            end else begin
                check("b2b_no_done", 64'(done), 64'd0);
            end
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub32_iter.md
Name: sub32_iter

Overview:
- Multi-cycle 32-bit unsigned subtractor with borrow; the inverse-operation companion to the registered 32-bit adder in the ALU datapath.
- Computes {bout_r, diff_r} = a - b - bin, one CHUNK-bit slice per cycle, LSB slice first, rippling the borrow between slices.
- Uses a start/busy/done handshake so the ALU sequencer can trade latency for a narrow borrow chain.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per RUN cycle; NSLICE = WIDTH/CHUNK (default 4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  global advance; when low, all state holds (stall).
- start  input  1  request a new operation; sampled only in IDLE with enable=1.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow in; sampled on the accepting edge only.
- busy  output  1  high in RUN and DONE.
- done  output  1  high for exactly one enabled cycle when the result is valid.
- diff_r  output  WIDTH  registered difference.
- bout_r  output  1  registered borrow out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, slice counter=0, internal borrow=0, operand registers=0, diff_r=0, bout_r=0, busy=0, done=0.
- States: IDLE, RUN, DONE. Every transition and register update requires enable=1. With enable=0, all registers hold, including a pending done=1.
- IDLE:
  - start=1 latches a, b and bin, clears the counter, loads internal borrow with bin, and moves to RUN.
  - diff_r and bout_r keep the previous result until the first RUN slice overwrites them.
- RUN, slice k = counter:
  - Compute {nb, d} = a[k*CHUNK +: CHUNK] - b[k*CHUNK +: CHUNK] - borrow, with CHUNK+1-bit arithmetic; nb is the borrow out of the slice.
  - Write diff_r[k*CHUNK +: CHUNK] = d. Set borrow = nb. Increment counter.
  - On the last slice (k = NSLICE-1): write bout_r = nb and move to DONE.
- DONE: done=1 for this cycle; next enabled edge returns to IDLE with done=0.
- Latency: start accepted at edge E0; slices at E1..E(NSLICE); done is high between E(NSLICE) and E(NSLICE+1). Default: done is visible after the 4th edge following acceptance.
- diff_r is only guaranteed correct while done=1 and afterwards in IDLE. During RUN it is partially updated.
- start while busy=1 is ignored; no queueing. Back-to-back: start in the IDLE cycle right after DONE is accepted normally.
- Operand changes after acceptance have no effect; internal copies are used.
- Reset mid-operation aborts immediately: all outputs return to reset values, and the next start proceeds normally.
- Arithmetic is modulo 2^WIDTH. Invariant: diff_r = (a - b - bin) mod 2^WIDTH, and bout_r = 1 iff the true result is negative.
- Simultaneous start and enable=0: start is not sampled.

Test Plan:
- Basic: rst pulse, then a=5, b=3, bin=0, start 1 cycle -> done pulses once exactly 4 cycles after acceptance, diff_r=0x00000002, bout_r=0, busy high for 5 cycles.
- Underflow: a=0, b=1, bin=0 -> diff_r=0xFFFFFFFF, bout_r=1.
- Cross-slice borrow ripple: a=0x01000000, b=0x00000001, bin=0 -> diff_r=0x00FFFFFF, bout_r=0. Also a=b=0xFFFFFFFF, bin=1 -> diff_r=0xFFFFFFFF, bout_r=1.
- Stall and ignored start: a=0x12345678, b=0x01020304; drop enable for 2 cycles during RUN and pulse start while busy -> done delayed by exactly 2 cycles, diff_r=0x11325374, bout_r=0, one operation only; a done pulse held across an enable=0 cycle stays high.
- Reset mid-run: assert rst=0 after 2 RUN slices -> diff_r=0, bout_r=0, busy=0, done=0 asynchronously. Next start with a=10, b=20 -> diff_r=0xFFFFFFF6, bout_r=1.
- Back-to-back: start held high continuously with operands changing each cycle -> each op is accepted only in IDLE, one done per op every 6 cycles, each result matches the operands sampled at its acceptance edge.
